// File: rtl/writeback_regfile.sv
// Writeback-stage register file: 15 x 64-bit registers with two combinational
// read ports, plus a sticky program status, a halt latch and a retired-instruction counter.
module writeback_regfile (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  W_status,
  input  logic [3:0]  W_icode,
  input  logic [3:0]  W_dste,
  input  logic [3:0]  W_dstm,
  input  logic [63:0] W_vale,
  input  logic [63:0] W_valm,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  output logic [63:0] d_rvalA,
  output logic [63:0] d_rvalB,
  output logic [1:0]  prog_stat,
  output logic        halted,
  output logic [31:0] retired_count
);

  localparam int unsigned XLEN   = 64;
  localparam int unsigned NREG   = 15;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned STAT_W = 2;

  localparam logic [STAT_W-1:0] STAT_AOK  = 2'b00;
  localparam logic [3:0]        REG_NONE  = 4'hF;
  localparam logic [3:0]        ICODE_NOP = 4'h1;

  logic [XLEN-1:0]   rf_q [NREG];
  logic [XLEN-1:0]   rf_d [NREG];
  logic [STAT_W-1:0] stat_q, stat_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic running;
  logic wr_en;
  logic retire;

  assign running = ~halted_q;
  assign wr_en   = running && (W_status == STAT_AOK);
  assign retire  = wr_en && (W_icode != ICODE_NOP);

  // Next-state array: the memory port is applied after the ALU port so it wins on a collision.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      rf_d[i] = rf_q[i];
      if (wr_en && (W_dste == 4'(i))) rf_d[i] = W_vale;
      if (wr_en && (W_dstm == 4'(i))) rf_d[i] = W_valm;
    end
  end

  // Status, halt latch and retirement counter.
  always_comb begin
    stat_d   = stat_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    if (running && (W_status != STAT_AOK)) begin
      halted_d = 1'b1;
      stat_d   = W_status;
    end
    if (retire) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      stat_q   <= STAT_AOK;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
      stat_q   <= stat_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  // Read ports see only stored state; id F reads as zero.
  always_comb begin
    d_rvalA = '0;
    d_rvalB = '0;
    if (d_srcA != REG_NONE) d_rvalA = rf_q[d_srcA];
    if (d_srcB != REG_NONE) d_rvalB = rf_q[d_srcB];
  end

  assign prog_stat     = stat_q;
  assign halted        = halted_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile.
module tb_writeback_regfile;

  logic        clock;
  logic        reset_n;
  logic [1:0]  W_status;
  logic [3:0]  W_icode;
  logic [3:0]  W_dste;
  logic [3:0]  W_dstm;
  logic [63:0] W_vale;
  logic [63:0] W_valm;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [63:0] d_rvalA;
  logic [63:0] d_rvalB;
  logic [1:0]  prog_stat;
  logic        halted;
  logic [31:0] retired_count;

  int n_checks = 0;
  int n_pass   = 0;

  writeback_regfile dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .W_status      (W_status),
    .W_icode       (W_icode),
    .W_dste        (W_dste),
    .W_dstm        (W_dstm),
    .W_vale        (W_vale),
    .W_valm        (W_valm),
    .d_srcA        (d_srcA),
    .d_srcB        (d_srcB),
    .d_rvalA       (d_rvalA),
    .d_rvalB       (d_rvalB),
    .prog_stat     (prog_stat),
    .halted        (halted),
    .retired_count (retired_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] st, input logic [3:0] ic,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm);
    W_status = st; W_icode = ic; W_dste = de; W_vale = ve; W_dstm = dm; W_valm = vm;
  endtask

  task automatic bubble();
    drive(2'b00, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
  endtask

  // One rising edge, then settle at the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] b);
    d_srcA = a;
    d_srcB = b;
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    bubble();
    d_srcA = 4'h0;
    d_srcB = 4'hF;
    #2;
    check("rst_rvalA", d_rvalA, 64'h0);
    check("rst_rvalB", d_rvalB, 64'h0);
    check("rst_stat", 64'(prog_stat), 64'h0);
    check("rst_halted", 64'(halted), 64'h0);
    check("rst_count", 64'(retired_count), 64'h0);

    @(negedge clock);
    reset_n = 1'b1;

    // Single ALU write, no same-cycle bypass.
    drive(2'b00, 4'h2, 4'h3, 64'h1234, 4'hF, 64'h0);
    rd(4'h3, 4'hF);
    check("no_bypass", d_rvalA, 64'h0);
    step();
    bubble();
    rd(4'h3, 4'hF);
    check("wr_reg3", d_rvalA, 64'h1234);
    check("wr_count", 64'(retired_count), 64'd1);

    // Same destination: memory result wins.
    drive(2'b00, 4'h5, 4'h4, 64'hAA, 4'h4, 64'hBB);
    step();
    bubble();
    rd(4'h4, 4'h3);
    check("dual_same_reg4", d_rvalA, 64'hBB);
    check("dual_same_reg3", d_rvalB, 64'h1234);
    check("dual_same_count", 64'(retired_count), 64'd2);

    // Different destinations both land.
    drive(2'b00, 4'h5, 4'h4, 64'h1111, 4'h5, 64'h2222);
    step();
    bubble();
    rd(4'h4, 4'h5);
    check("dual_diff_reg4", d_rvalA, 64'h1111);
    check("dual_diff_reg5", d_rvalB, 64'h2222);
    check("dual_diff_count", 64'(retired_count), 64'd3);

    // Bubbles for five cycles.
    for (int i = 0; i < 5; i++) step();
    rd(4'h3, 4'h5);
    check("bubble_count", 64'(retired_count), 64'd3);
    check("bubble_reg3", d_rvalA, 64'h1234);
    check("bubble_reg5", d_rvalB, 64'h2222);

    // Counter wrap from all-ones.
    dut.cnt_q = 32'hFFFF_FFFF;
    drive(2'b00, 4'h6, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    bubble();
    #1;
    check("wrap_count", 64'(retired_count), 64'd0);

    // Halt: no write, not counted, then everything frozen.
    drive(2'b01, 4'h0, 4'h2, 64'h55, 4'hF, 64'h0);
    step();
    bubble();
    rd(4'h2, 4'hF);
    check("halt_flag", 64'(halted), 64'd1);
    check("halt_stat", 64'(prog_stat), 64'd1);
    check("halt_reg2", d_rvalA, 64'h0);
    check("halt_count", 64'(retired_count), 64'd0);
    drive(2'b00, 4'h2, 4'h3, 64'h999, 4'h5, 64'h777);
    step();
    drive(2'b10, 4'h2, 4'h3, 64'h999, 4'hF, 64'h0);
    step();
    bubble();
    rd(4'h3, 4'h5);
    check("frozen_reg3", d_rvalA, 64'h1234);
    check("frozen_reg5", d_rvalB, 64'h2222);
    check("frozen_count", 64'(retired_count), 64'd0);
    check("frozen_stat", 64'(prog_stat), 64'd1);
    check("frozen_halted", 64'(halted), 64'd1);

    // Reset while halted, then error status and an asynchronous mid-cycle reset.
    reset_n = 1'b0;
    #1;
    check("rst_halted_clear", 64'(halted), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(2'b00, 4'h2, 4'h7, 64'h77, 4'hF, 64'h0);
    step();
    drive(2'b10, 4'h2, 4'h8, 64'h88, 4'hF, 64'h0);
    step();
    bubble();
    rd(4'h7, 4'h8);
    check("err_stat", 64'(prog_stat), 64'd2);
    check("err_reg7", d_rvalA, 64'h77);
    check("err_reg8", d_rvalB, 64'h0);
    check("err_count", 64'(retired_count), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_stat", 64'(prog_stat), 64'd0);
    check("async_halted", 64'(halted), 64'd0);
    check("async_count", 64'(retired_count), 64'd0);
    check("async_reg7", d_rvalA, 64'h0);

    // Writes are ignored while reset is held.
    drive(2'b00, 4'h2, 4'h9, 64'h99, 4'hF, 64'h0);
    step();
    rd(4'h9, 4'hF);
    check("inreset_reg9", d_rvalA, 64'h0);
    check("inreset_count", 64'(retired_count), 64'd0);

    // First edge after release performs the write.
    reset_n = 1'b1;
    drive(2'b00, 4'h2, 4'h8, 64'h88, 4'hF, 64'h0);
    step();
    bubble();
    rd(4'h8, 4'hF);
    check("post_rst_reg8", d_rvalA, 64'h88);
    check("post_rst_count", 64'(retired_count), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clock  in  1  sole clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- W_status  in  2  writeback-stage status (00 AOK, 01 HLT, 10 ADR, 11 INS)
- W_icode  in  4  writeback-stage instruction code (4'h1 = nop/bubble)
- W_dste  in  4  destination register for W_vale; 4'hF = none
- W_dstm  in  4  destination register for W_valm; 4'hF = none
- W_vale  in  64  ALU result to write
- W_valm  in  64  memory result to write
- d_srcA  in  4  decode read address A; 4'hF = none
- d_srcB  in  4  decode read address B; 4'hF = none
- d_rvalA  out  64  register value for d_srcA
- d_rvalB  out  64  register value for d_srcB
- prog_stat  out  2  sticky program status
- halted  out  1  1 once a non-AOK status has retired
- retired_count  out  32  count of retired non-bubble instructions

Function
REQ-002 Storage SHALL be 15 registers of 64 bits, ids 4'h0 to 4'hE.
REQ-003 d_rvalA and d_rvalB SHALL be combinational reads of the stored array, with no same-cycle bypass of W_vale/W_valm; reads of 4'hF SHALL return 64'h0.
REQ-004 The array SHALL be written only at a rising clock edge where halted==0 and W_status==AOK.
REQ-005 On an enabled edge, if W_dste!=4'hF, register W_dste SHALL be loaded with W_vale.
REQ-006 On an enabled edge, if W_dstm!=4'hF, register W_dstm SHALL be loaded with W_valm.
REQ-007 If W_dste==W_dstm!=4'hF on an enabled edge, W_valm SHALL win and W_vale SHALL be discarded.
REQ-008 Writes SHALL be visible on d_rvalA/d_rvalB in the cycle after the write edge, giving one-cycle write-to-read latency.
REQ-009 At an edge where halted==0 and W_status!=AOK, the block SHALL set halted=1 and load prog_stat with W_status, with no register write in that cycle.
REQ-010 Once halted==1, halted, prog_stat and the array SHALL hold all values until reset, whatever the later W_status or destination inputs.
REQ-011 While halted==0, prog_stat SHALL read AOK.
REQ-012 retired_count SHALL increment by 1 at each edge where halted==0, W_status==AOK and W_icode!=4'h1.
REQ-013 retired_count SHALL wrap from 32'hFFFFFFFF to 0 without flag.
REQ-014 The HLT-status instruction SHALL NOT be counted; the count SHALL be frozen while halted==1.
REQ-015 The block SHALL have no stall input; the upstream register holds W_* stable during stalls, and repeated identical writes SHALL be harmless.
REQ-016 A held non-bubble instruction SHALL be counted once per edge; upstream inserts bubbles (icode 4'h1) when the count must not advance.

Reset
REQ-017 When reset_n is low, the block SHALL immediately, without waiting for clock, clear all 15 registers to 64'h0, prog_stat to AOK, halted to 0 and retired_count to 0.
REQ-018 While reset_n is low, the block SHALL ignore all writes and counting.
REQ-019 Reset asserted mid-operation, including while halted, SHALL fully restore the state in REQ-017.
REQ-020 The first enabled write SHALL occur at the first rising edge after reset_n goes high.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Write: W_status=00, W_icode=2, W_dste=3, W_vale=64'h1234, W_dstm=F -> next cycle d_srcA=3 gives 64'h1234; retired_count=1.
- Dual write, same register: W_dste=W_dstm=4, W_vale=64'hAA, W_valm=64'hBB -> reg4=64'hBB.
- Dual write, different registers: W_dste=4, W_dstm=5 -> reg4=W_vale, reg5=W_valm.
- Bubble: W_icode=1, both destinations F for 5 cycles -> retired_count unchanged; array unchanged.
- Halt: W_status=01 with W_dste=2, W_vale=64'h55 -> halted=1, prog_stat=01, reg2 unchanged; later AOK writes ignored and count frozen.
- Error status: W_status=10 -> prog_stat=10; reset_n pulsed low mid-cycle -> outputs clear immediately, all reads 0.
- Counter wrap: retired_count preloaded to 32'hFFFFFFFF via stimulus, one non-bubble AOK edge -> retired_count=0.
